// File: rtl/uart_pkg.sv
// Shared UART constants: default baud divisors, oversample ratio and the
// helpers that derive the oversample phase width and the tick bundle type.
package uart_pkg;

   localparam int DEF_DIV_W      = 16;
   localparam int DEF_FRAC_W     = 8;
   localparam int DEF_OVERSAMPLE = 16;
   // 50 MHz / (9600 * 16) = 325.52 -> integer 325, fraction 0.52 * 256 = 133
   localparam int DEF_INT_DIV    = 325;
   localparam int DEF_FRAC_DIV   = 133;
   localparam int MIN_DIV        = 2;

   typedef struct packed {
      logic os;
      logic tx;
      logic rx;
   } tick_t;

   localparam tick_t TICKS_IDLE = 3'b000;

   function automatic int phase_w(input int os_ratio);
      return $clog2(os_ratio);
   endfunction

endpackage

// File: rtl/brg_frac_div.sv
// Fractional period counter: active/shadow divisors, phase accumulator and the
// reload pulse that marks the end of every oversample period.
module brg_frac_div
   import uart_pkg::*;
#(
   parameter int DIV_W    = DEF_DIV_W,
   parameter int FRAC_W   = DEF_FRAC_W,
   parameter int DEF_INT  = DEF_INT_DIV,
   parameter int DEF_FRAC = DEF_FRAC_DIV
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_en,
   input  logic              i_div_wr,
   input  logic [DIV_W-1:0]  i_div_int,
   input  logic [FRAC_W-1:0] i_div_frac,
   output logic              o_reload,
   output logic              o_div_pend
);

   localparam logic [DIV_W-1:0]  INT_RST   = DIV_W'(DEF_INT);
   localparam logic [FRAC_W-1:0] FRAC_RST  = FRAC_W'(DEF_FRAC);
   localparam logic [DIV_W-1:0]  INT_MIN   = DIV_W'(MIN_DIV);
   localparam logic [FRAC_W-1:0] ACC_ZERO  = FRAC_W'(0);
   localparam logic [DIV_W:0]    CNT_ZERO  = (DIV_W+1)'(0);
   localparam logic [DIV_W:0]    CNT_ONE   = (DIV_W+1)'(1);

   logic [DIV_W-1:0]  r_int;
   logic [FRAC_W-1:0] r_frac;
   logic [DIV_W-1:0]  r_sh_int;
   logic [FRAC_W-1:0] r_sh_frac;
   logic [FRAC_W-1:0] r_acc;
   logic [DIV_W:0]    r_cnt;
   logic              r_pend;

   logic [FRAC_W:0]   w_sum;
   logic [DIV_W-1:0]  w_int_eff;
   logic [DIV_W:0]    w_len_m1;
   logic              w_reload;
   logic              w_apply;

   // Current period length is the clamped integer plus the accumulator carry.
   always_comb begin
      w_sum = {1'b0, r_acc} + {1'b0, r_frac};
      if (r_int < INT_MIN) begin
         w_int_eff = INT_MIN;
      end else begin
         w_int_eff = r_int;
      end
      w_len_m1 = {1'b0, w_int_eff} + {{DIV_W{1'b0}}, w_sum[FRAC_W]} - CNT_ONE;
      w_reload = i_en && (r_cnt == w_len_m1);
      // Stopped generator takes the shadow at once; running one waits for a reload.
      w_apply  = r_pend && (!i_en || w_reload);
   end

   // Shadow divisor capture; the last write before the apply point wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sh_int  <= INT_RST;
         r_sh_frac <= FRAC_RST;
      end else if (i_div_wr) begin
         r_sh_int  <= i_div_int;
         r_sh_frac <= i_div_frac;
      end
   end

   // Pending flag; a write landing on the apply cycle keeps it set for the next one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pend <= 1'b0;
      end else if (i_div_wr) begin
         r_pend <= 1'b1;
      end else if (w_apply) begin
         r_pend <= 1'b0;
      end
   end

   // Active divisor, accumulator and cycle counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_int  <= INT_RST;
         r_frac <= FRAC_RST;
         r_acc  <= ACC_ZERO;
         r_cnt  <= CNT_ZERO;
      end else if (w_apply) begin
         r_int  <= r_sh_int;
         r_frac <= r_sh_frac;
         r_acc  <= ACC_ZERO;
         r_cnt  <= CNT_ZERO;
      end else if (w_reload) begin
         r_acc  <= w_sum[FRAC_W-1:0];
         r_cnt  <= CNT_ZERO;
      end else if (i_en) begin
         r_cnt  <= r_cnt + CNT_ONE;
      end
   end

   assign o_reload   = w_reload;
   assign o_div_pend = r_pend;

endmodule

// File: rtl/brg_frac.sv
// Fractional baud-rate generator: oversample tick from brg_frac_div, plus the
// tx bit-rate and rx mid-bit phase counters and the registered tick outputs.
module brg_frac
   import uart_pkg::*;
#(
   parameter int DIV_W      = DEF_DIV_W,
   parameter int FRAC_W     = DEF_FRAC_W,
   parameter int OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int DEF_INT    = DEF_INT_DIV,
   parameter int DEF_FRAC   = DEF_FRAC_DIV
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              div_wr,
   input  logic [DIV_W-1:0]  div_int_in,
   input  logic [FRAC_W-1:0] div_frac_in,
   input  logic              rx_restart,
   output logic              os_tick,
   output logic              tx_tick,
   output logic              rx_sample,
   output logic              div_pend
);

   localparam int              PH_W    = phase_w(OVERSAMPLE);
   localparam logic [PH_W-1:0] PH_ZERO = PH_W'(0);
   localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
   localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2 - 1);

   logic            w_reload;
   logic            w_div_pend;
   logic [PH_W-1:0] r_tx_phase;
   logic [PH_W-1:0] r_rx_phase;
   tick_t           r_ticks;
   tick_t           w_ticks_nxt;

   brg_frac_div #(
      .DIV_W    (DIV_W),
      .FRAC_W   (FRAC_W),
      .DEF_INT  (DEF_INT),
      .DEF_FRAC (DEF_FRAC)
   ) u_div (
      .clk        (clk),
      .reset      (reset),
      .i_en       (en),
      .i_div_wr   (div_wr),
      .i_div_int  (div_int_in),
      .i_div_frac (div_frac_in),
      .o_reload   (w_reload),
      .o_div_pend (w_div_pend)
   );

   // Tick decode; a coincident rx_restart swallows the mid-bit sample only.
   always_comb begin
      w_ticks_nxt    = TICKS_IDLE;
      w_ticks_nxt.os = w_reload;
      w_ticks_nxt.tx = w_reload && (r_tx_phase == PH_LAST);
      w_ticks_nxt.rx = w_reload && !rx_restart && (r_rx_phase == PH_MID);
   end

   // Transmit phase: free-running modulo OVERSAMPLE on each oversample tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tx_phase <= PH_ZERO;
      end else if (w_reload) begin
         r_tx_phase <= r_tx_phase + PH_ONE;
      end
   end

   // Receive phase: realigned to a start-bit edge by rx_restart.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_phase <= PH_ZERO;
      end else if (rx_restart) begin
         r_rx_phase <= PH_ZERO;
      end else if (w_reload) begin
         r_rx_phase <= r_rx_phase + PH_ONE;
      end
   end

   // Output tick flops: each pulse lasts exactly one clk cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ticks <= TICKS_IDLE;
      end else begin
         r_ticks <= w_ticks_nxt;
      end
   end

   assign os_tick   = r_ticks.os;
   assign tx_tick   = r_ticks.tx;
   assign rx_sample = r_ticks.rx;
   assign div_pend  = w_div_pend;

endmodule

// File: doc/brg_frac.md
BRG_FRAC -- requirements
Module: brg_frac

Interface
REQ-001 SHALL have parameter DIV_W, default 16, integer divisor width.
REQ-002 SHALL have parameter FRAC_W, default 8, fractional divisor width.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, os ticks per bit; power of two, minimum 4.
REQ-004 SHALL have parameter DEF_INT, default 325, reset integer divisor (50 MHz / (9600*16) = 325.52).
REQ-005 SHALL have parameter DEF_FRAC, default 133, reset fractional divisor (0.52*256).
REQ-006 SHALL have port clk, input, 1, system clock.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-008 SHALL have port en, input, 1, generator run enable.
REQ-009 SHALL have port div_wr, input, 1, one-cycle divisor write strobe.
REQ-010 SHALL have port div_int_in, input, DIV_W, integer divisor write data.
REQ-011 SHALL have port div_frac_in, input, FRAC_W, fractional divisor write data.
REQ-012 SHALL have port rx_restart, input, 1, realigns rx phase on a start-bit edge.
REQ-013 SHALL have port os_tick, output, 1, oversample pulse.
REQ-014 SHALL have port tx_tick, output, 1, bit-rate pulse.
REQ-015 SHALL have port rx_sample, output, 1, mid-bit sample pulse.
REQ-016 SHALL have port div_pend, output, 1, written divisor not yet applied.

Function
REQ-017 SHALL register all outputs; each tick SHALL be high exactly one clk cycle per event, never a toggled clock.
REQ-018 SHALL make each os period div_int + c cycles, where c is the carry out of acc + div_frac, computed at each period reload with acc <= (acc + div_frac) mod 2^FRAC_W.
REQ-019 SHALL clamp any active div_int below 2 to 2.
REQ-020 SHALL capture div_int_in/div_frac_in into a shadow register on div_wr and set div_pend the next cycle.
REQ-021 SHALL let a div_wr while div_pend is high overwrite the shadow, so the last write wins.
REQ-022 SHALL, while en=1, apply the shadow at the next period reload: the new period starts from the new values, acc is cleared, and div_pend clears.
REQ-023 SHALL, while en=0, apply the shadow immediately, with acc and cnt cleared; div_pend SHALL clear the cycle after div_wr.
REQ-024 SHALL, while en=0, hold cnt and both phase counters and force all ticks low.
REQ-025 SHALL, when en rises, emit the first os_tick after one full period.
REQ-026 SHALL advance tx_phase mod OVERSAMPLE on each os_tick and assert tx_tick with the os_tick on which tx_phase wraps from OVERSAMPLE-1 to 0.
REQ-027 SHALL advance rx_phase mod OVERSAMPLE on each os_tick and assert rx_sample with the os_tick on which rx_phase = OVERSAMPLE/2-1 before increment; this is the 8th os_tick after rx_restart for 16x, then every 16 thereafter.
REQ-028 SHALL, on rx_restart, clear rx_phase and leave cnt, acc and tx_phase untouched.
REQ-029 SHALL let rx_restart win when it coincides with an os_tick: rx_phase = 0, that tick is not counted, rx_sample is suppressed, and os_tick/tx_tick are still emitted.
REQ-030 SHALL apply a div_wr coinciding with a reload at the following reload, with div_pend high in between.

Reset
REQ-031 SHALL, on reset, set active and shadow divisors to DEF_INT/DEF_FRAC, clear cnt, acc, tx_phase and rx_phase, and drive all outputs 0.
REQ-032 SHALL abort any in-progress period or pending write on reset assertion mid-operation; the first os_tick after release SHALL come one full DEF period after the first en=1 cycle.

Structure
REQ-033 SHALL define default constants and OVERSAMPLE-derived widths (phase width = log2(OVERSAMPLE)) in shared package uart_pkg.
REQ-034 SHALL place the fractional period counter (cnt, acc, shadow/apply logic) in sub-module brg_frac_div; phase counters and output flops SHALL live in brg_frac.

Verification
REQ-035 SHALL cover defaults with en=1: 256 consecutive os periods sum to 83333 cycles, and tx_tick occurs every 16th os_tick.
REQ-036 SHALL cover en=0, write int=4/frac=128, then en=1: os periods alternate 4,5,4,5 and div_pend is high for exactly 1 cycle.
REQ-037 SHALL cover en=1, int=10/frac=0, write int=6 mid-period: the current period completes in 10 cycles, the next is 6, and div_pend is high until that reload.
REQ-038 SHALL cover rx_restart pulsed coincident with an os_tick: rx_sample first occurs on the 8th subsequent os_tick, then every 16th, and tx_tick timing is unchanged.
REQ-039 SHALL cover write int=0 or int=1: period is 2 cycles.
REQ-040 SHALL cover reset asserted mid-period with a write pending: outputs go to 0 immediately, div_pend=0, and DEF timing resumes after release.
